// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial RAM port controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Byte count of an LS access; the illegal size code 3 behaves as a word.
  function automatic logic [CNT_W-1:0] xfer_len(input logic [1:0] size);
    case (size)
      SZ_B:    return CNT_W'(1);
      SZ_H:    return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM-port signals of mem_ctrl; slave is the controller side.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              rdy;
  logic              flush;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_done;
  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_done;
  logic [BYTE_W-1:0] mem_din;
  logic [BYTE_W-1:0] mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport master (
    output rdy, flush, if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
    input  if_data, if_done, ls_rdata, ls_done, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  rdy, flush, if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
    output if_data, if_done, ls_rdata, ls_done, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM port between fetch and load/store, serialising
// each access into little-endian byte transactions.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter bit LS_PRIORITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  mc_state_e         state;
  owner_e            owner;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len;
  logic [ADDR_W-1:0] mem_a_q;
  logic [BYTE_W-1:0] mem_dout_q;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic              wr_phase;
  logic              if_done_q;
  logic              ls_done_q;

  logic              grant_ls_c;
  logic              grant_if_c;
  logic [1:0]        byte_idx_c;
  logic [DATA_W-1:0] rdata_nxt_c;

  // Grant decision and merge of the byte returned for the previous address.
  always_comb begin
    grant_ls_c  = bus.ls_req && (LS_PRIORITY || !bus.if_req || bus.flush);
    grant_if_c  = bus.if_req && !bus.flush && !grant_ls_c;
    byte_idx_c  = 2'(cnt - CNT_W'(1));
    rdata_nxt_c = rdata;
    if (cnt != '0) begin
      rdata_nxt_c[{byte_idx_c, 3'b000} +: BYTE_W] = bus.mem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MC_IDLE;
      owner      <= OWN_IF;
      cnt        <= '0;
      len        <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      wdata      <= '0;
      rdata      <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      wr_phase   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else if (bus.rdy) begin
      case (state)
        MC_IDLE: begin
          if (grant_ls_c || grant_if_c) begin
            owner      <= grant_ls_c ? OWN_LS : OWN_IF;
            len        <= grant_ls_c ? xfer_len(bus.ls_size) : CNT_W'(4);
            mem_a_q    <= grant_ls_c ? bus.ls_addr : bus.if_addr;
            wdata      <= bus.ls_wdata;
            mem_dout_q <= bus.ls_wdata[BYTE_W-1:0];
            cnt        <= '0;
            rdata      <= '0;
            if (grant_ls_c && bus.ls_we) begin
              state    <= MC_WRITE;
              wr_phase <= 1'b1;
            end else begin
              state    <= MC_READ;
            end
          end
        end
        MC_READ: begin
          if (owner == OWN_IF && bus.flush) begin
            state <= MC_IDLE;
            cnt   <= '0;
          end else if (cnt == len) begin
            state <= MC_DONE;
            if (owner == OWN_IF) begin
              if_data_q <= rdata_nxt_c;
              if_done_q <= 1'b1;
            end else begin
              ls_rdata_q <= rdata_nxt_c;
              ls_done_q  <= 1'b1;
            end
          end else begin
            rdata <= rdata_nxt_c;
            cnt   <= cnt + CNT_W'(1);
            // Address stays on the last byte during the final capture cycle.
            if (cnt + CNT_W'(1) < len) begin
              mem_a_q <= mem_a_q + ADDR_W'(1);
            end
          end
        end
        MC_WRITE: begin
          if (cnt == len - CNT_W'(1)) begin
            state     <= MC_DONE;
            wr_phase  <= 1'b0;
            ls_done_q <= 1'b1;
          end else begin
            cnt        <= cnt + CNT_W'(1);
            mem_a_q    <= mem_a_q + ADDR_W'(1);
            wdata      <= wdata >> BYTE_W;
            mem_dout_q <= wdata[2*BYTE_W-1:BYTE_W];
          end
        end
        MC_DONE: begin
          state     <= MC_IDLE;
          if_done_q <= 1'b0;
          ls_done_q <= 1'b0;
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

  assign bus.if_data  = if_data_q;
  assign bus.if_done  = if_done_q & ~bus.flush;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = wr_phase & bus.rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();

  mem_ctrl #(.LS_PRIORITY(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        is_ls;
    logic        chk;
    logic [31:0] data;
    logic [31:0] cyc;
  } done_t;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  done_t exp_done[$];
  wr_t   exp_wr[$];
  done_t de;
  wr_t   we_item;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  logic [7:0]  ram [0:4095];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM returns the byte addressed in the previous cycle.
  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[11:0]];
    if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_done && bus.ls_done) check("done_overlap", 32'd1, 32'd0);
      if ((bus.if_done || bus.ls_done) && bus.rdy) begin
        if (exp_done.size() == 0) begin
          check("spurious_done", {30'd0, bus.ls_done, bus.if_done}, 32'd0);
        end else begin
          de = exp_done.pop_front();
          check("done_owner", 32'(bus.ls_done), 32'(de.is_ls));
          if (de.chk) check("done_data", bus.ls_done ? bus.ls_rdata : bus.if_data, de.data);
          check("done_cycle", cyc, de.cyc);
        end
      end
      if (bus.mem_wr) begin
        if (exp_wr.size() == 0) begin
          check("spurious_write", bus.mem_a, 32'hFFFF_FFFF);
        end else begin
          we_item = exp_wr.pop_front();
          check("wr_addr", bus.mem_a, we_item.a);
          check("wr_byte", 32'(bus.mem_dout), 32'(we_item.d));
        end
      end
    end
  end

  task automatic goto_pos(input int unsigned target);
    do begin @(posedge clk); #1; end while (cyc < target);
  endtask

  task automatic goto_neg(input int unsigned target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic wait_done(input bit is_ls);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((is_ls ? bus.ls_done : bus.if_done) && bus.rdy) && n < 100);
    if (n >= 100) check(is_ls ? "ls_timeout" : "if_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic if_op(input logic [31:0] addr, input logic [31:0] exp, input bit chk_addr);
    int unsigned c;
    @(posedge clk); #1;
    c = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    exp_done.push_back('{is_ls: 1'b0, chk: 1'b1, data: exp, cyc: c + 6});
    if (chk_addr) begin
      for (int k = 1; k <= 4; k++) begin
        goto_neg(c + k);
        check("if_mem_a", bus.mem_a, addr + 32'(k - 1));
        check("if_mem_wr", 32'(bus.mem_wr), 32'd0);
      end
    end
    wait_done(1'b0);
    bus.if_req = 1'b0;
  endtask

  task automatic ls_op(input bit we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp,
                       input int unsigned chk_k, input logic [31:0] chk_a);
    int unsigned c;
    int unsigned n;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    @(posedge clk); #1;
    c = cyc;
    bus.ls_req   = 1'b1;
    bus.ls_we    = we;
    bus.ls_size  = size;
    bus.ls_addr  = addr;
    bus.ls_wdata = wd;
    if (we) begin
      for (int i = 0; i < int'(n); i++) exp_wr.push_back('{a: addr + 32'(i), d: wd[8*i +: 8]});
      exp_done.push_back('{is_ls: 1'b1, chk: 1'b0, data: 32'd0, cyc: c + n + 1});
    end else begin
      exp_done.push_back('{is_ls: 1'b1, chk: 1'b1, data: exp, cyc: c + n + 2});
    end
    if (chk_k != 0) begin
      goto_neg(c + chk_k);
      check("ls_mem_a", bus.mem_a, chk_a);
    end
    wait_done(1'b1);
    bus.ls_req = 1'b0;
  endtask

  initial begin
    int unsigned c;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h203] = 8'h80;
    ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;

    rst = 1'b1;
    bus.rdy = 1'b1; bus.flush = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_data", bus.if_data, 32'd0);
    check("rst_if_done", 32'(bus.if_done), 32'd0);
    check("rst_ls_rdata", bus.ls_rdata, 32'd0);
    check("rst_ls_done", 32'(bus.ls_done), 32'd0);
    check("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    if_op(32'h100, 32'h0000_0513, 1'b1);
    ls_op(1'b0, 2'd0, 32'h203, 32'h0, 32'h0000_0080, 0, 32'h0);
    ls_op(1'b1, 2'd2, 32'h200, 32'hDEAD_BEEF, 32'h0, 0, 32'h0);
    ls_op(1'b0, 2'd2, 32'h200, 32'h0, 32'hDEAD_BEEF, 0, 32'h0);
    ls_op(1'b0, 2'd1, 32'h201, 32'h0, 32'h0000_ADBE, 0, 32'h0);
    ls_op(1'b0, 2'd3, 32'h100, 32'h0, 32'h0000_0513, 0, 32'h0);
    ls_op(1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 32'h4433_2211, 3, 32'h0);

    // Simultaneous requests: LS first, DONE bubble, then IF.
    @(posedge clk); #1;
    c = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd1; bus.ls_addr = 32'h100;
    exp_done.push_back('{is_ls: 1'b1, chk: 1'b1, data: 32'h0000_0513, cyc: c + 4});
    exp_done.push_back('{is_ls: 1'b0, chk: 1'b1, data: 32'h0000_0513, cyc: c + 11});
    wait_done(1'b1);
    bus.ls_req = 1'b0;
    wait_done(1'b0);
    bus.if_req = 1'b0;

    // Flush mid-fetch with an LS request queued behind it.
    @(posedge clk); #1;
    c = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    goto_pos(c + 1);
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd0; bus.ls_addr = 32'h203;
    exp_done.push_back('{is_ls: 1'b1, chk: 1'b1, data: 32'h0000_00DE, cyc: c + 6});
    goto_pos(c + 2);
    bus.flush = 1'b1; bus.if_req = 1'b0;
    goto_pos(c + 3);
    bus.flush = 1'b0;
    wait_done(1'b1);
    bus.ls_req = 1'b0;

    // Flush during DONE hides if_done.
    @(posedge clk); #1;
    c = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    goto_pos(c + 6);
    bus.flush = 1'b1;
    goto_neg(c + 6);
    check("flush_done_if_done", 32'(bus.if_done), 32'd0);
    goto_pos(c + 7);
    bus.flush = 1'b0; bus.if_req = 1'b0;

    // Store stalled by rdy=0 for three cycles.
    @(posedge clk); #1;
    c = cyc;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd2;
    bus.ls_addr = 32'h300; bus.ls_wdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back('{a: 32'h300 + 32'(i), d: 8'(32'h1234_5678 >> (8 * i))});
    end
    exp_done.push_back('{is_ls: 1'b1, chk: 1'b0, data: 32'd0, cyc: c + 8});
    goto_pos(c + 2);
    bus.rdy = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      goto_neg(c + k);
      check("stall_mem_wr", 32'(bus.mem_wr), 32'd0);
    end
    goto_pos(c + 5);
    bus.rdy = 1'b1;
    wait_done(1'b1);
    bus.ls_req = 1'b0;
    ls_op(1'b0, 2'd2, 32'h300, 32'h0, 32'h1234_5678, 0, 32'h0);

    // Reset in the middle of a word load.
    @(posedge clk); #1;
    c = cyc;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd2;
    bus.ls_addr = 32'h100; bus.ls_wdata = 32'h0000_00A5;
    goto_pos(c + 3);
    rst = 1'b1; bus.ls_req = 1'b0;
    goto_pos(c + 4);
    rst = 1'b0;
    goto_neg(c + 4);
    check("mrst_if_data", bus.if_data, 32'd0);
    check("mrst_ls_rdata", bus.ls_rdata, 32'd0);
    check("mrst_ls_done", 32'(bus.ls_done), 32'd0);
    check("mrst_mem_a", bus.mem_a, 32'd0);
    check("mrst_mem_dout", 32'(bus.mem_dout), 32'd0);
    check("mrst_mem_wr", 32'(bus.mem_wr), 32'd0);
    if_op(32'h100, 32'h0000_0513, 1'b0);

    repeat (4) @(posedge clk);
    check("sb_done_empty", 32'(exp_done.size()), 32'd0);
    check("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
